// File: rtl/data_bus_demux_if.sv
// data_bus_demux_if: bundles the core request/response handshake and the
// three-target steering bus used by data_bus_demux.
interface data_bus_demux_if;
   // core request side
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   // core response side
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   // target side
   logic [2:0]  tgt_req;
   logic        tgt_we;
   logic [31:0] tgt_addr;
   logic [31:0] tgt_wdata;
   logic [3:0]  tgt_be;
   logic [2:0]  tgt_ack;
   logic [31:0] tgt_rdata_0;
   logic [31:0] tgt_rdata_1;
   logic [31:0] tgt_rdata_2;

   // the demux itself
   modport slave (
      input  req_valid, req_we, req_addr, req_wdata, req_be,
      input  tgt_ack, tgt_rdata_0, tgt_rdata_1, tgt_rdata_2,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output tgt_req, tgt_we, tgt_addr, tgt_wdata, tgt_be
   );

   // core plus targets, seen from outside the demux
   modport master (
      output req_valid, req_we, req_addr, req_wdata, req_be,
      output tgt_ack, tgt_rdata_0, tgt_rdata_1, tgt_rdata_2,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  tgt_req, tgt_we, tgt_addr, tgt_wdata, tgt_be
   );
endinterface

// File: rtl/data_bus_demux.sv
// data_bus_demux: steers one load/store from the memory stage to instruction
// memory, data memory or the peripheral block, waits for that target's ack
// and returns a single-cycle response. Unmapped, misaligned, read-only-store
// and timed-out accesses come back as error responses with zero data.
module data_bus_demux #(
   parameter logic [31:0] IMEM_BASE = 32'h0100_0000,
   parameter logic [31:0] IMEM_MASK = 32'hFFFF_F000,
   parameter logic [31:0] DMEM_BASE = 32'h8000_0000,
   parameter logic [31:0] DMEM_MASK = 32'hFFFF_F000,
   parameter logic [31:0] PERI_BASE = 32'h0010_0000,
   parameter logic [31:0] PERI_MASK = 32'hFFFF_FF00,
   parameter int unsigned TIMEOUT   = 16
) (
   input  logic              clk,
   input  logic              rst,
   data_bus_demux_if.slave   bus
);

   // counter only needs to reach TIMEOUT-1
   localparam int unsigned          CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // selects the read data of the one-hot target; zero when nothing selected
   function automatic logic [31:0] pick_rdata(
      input logic [2:0]  sel,
      input logic [31:0] rd0,
      input logic [31:0] rd1,
      input logic [31:0] rd2
   );
      logic [31:0] res;
      case (sel)
         3'b001:  res = rd0;
         3'b010:  res = rd1;
         3'b100:  res = rd2;
         default: res = 32'h0000_0000;
      endcase
      return res;
   endfunction

   state_e            state_r,     next_state_s;
   logic [CNT_W-1:0]  cnt_r,       next_cnt_s;
   logic              ready_r,     next_ready_s;
   logic [2:0]        tgt_req_r,   next_tgt_req_s;
   logic              tgt_we_r,    next_tgt_we_s;
   logic [31:0]       tgt_addr_r,  next_tgt_addr_s;
   logic [31:0]       tgt_wdata_r, next_tgt_wdata_s;
   logic [3:0]        tgt_be_r,    next_tgt_be_s;
   logic              rsp_valid_r, next_rsp_valid_s;
   logic [31:0]       rsp_rdata_r, next_rsp_rdata_s;
   logic              rsp_err_r,   next_rsp_err_s;

   logic [2:0]        hit_s;
   logic [2:0]        sel_s;
   logic              dec_err_s;
   logic              accept_s;
   logic              ack_sel_s;
   logic [31:0]       ack_rdata_s;

   assign bus.req_ready = ready_r;
   assign bus.tgt_req   = tgt_req_r;
   assign bus.tgt_we    = tgt_we_r;
   assign bus.tgt_addr  = tgt_addr_r;
   assign bus.tgt_wdata = tgt_wdata_r;
   assign bus.tgt_be    = tgt_be_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_rdata = rsp_rdata_r;
   assign bus.rsp_err   = rsp_err_r;

   // address decode with fixed priority 0 > 1 > 2 and illegal-access detection
   always_comb begin
      hit_s[0] = ((bus.req_addr & IMEM_MASK) == IMEM_BASE);
      hit_s[1] = ((bus.req_addr & DMEM_MASK) == DMEM_BASE);
      hit_s[2] = ((bus.req_addr & PERI_MASK) == PERI_BASE);
      if (hit_s[0]) begin
         sel_s = 3'b001;
      end else if (hit_s[1]) begin
         sel_s = 3'b010;
      end else if (hit_s[2]) begin
         sel_s = 3'b100;
      end else begin
         sel_s = 3'b000;
      end
      // instruction memory is read-only from the data side
      dec_err_s = (sel_s == 3'b000) || (bus.req_addr[1:0] != 2'b00) ||
                  (sel_s[0] && bus.req_we);
   end

   // only the ack of the target currently being requested counts
   always_comb begin
      accept_s    = bus.req_valid && ready_r;
      ack_sel_s   = |(bus.tgt_ack & tgt_req_r);
      ack_rdata_s = pick_rdata(tgt_req_r, bus.tgt_rdata_0, bus.tgt_rdata_1, bus.tgt_rdata_2);
   end

   // next-state and next-output logic of the IDLE/WAIT/RESP controller
   always_comb begin
      next_state_s     = state_r;
      next_cnt_s       = cnt_r;
      next_tgt_req_s   = tgt_req_r;
      next_tgt_we_s    = tgt_we_r;
      next_tgt_addr_s  = tgt_addr_r;
      next_tgt_wdata_s = tgt_wdata_r;
      next_tgt_be_s    = tgt_be_r;
      next_rsp_valid_s = 1'b0;
      next_rsp_rdata_s = rsp_rdata_r;
      next_rsp_err_s   = rsp_err_r;

      case (state_r)
         ST_IDLE: begin
            if (accept_s && dec_err_s) begin
               // rejected before any target sees it
               next_state_s     = ST_RESP;
               next_rsp_valid_s = 1'b1;
               next_rsp_rdata_s = 32'h0000_0000;
               next_rsp_err_s   = 1'b1;
            end else if (accept_s) begin
               next_state_s     = ST_WAIT;
               next_tgt_req_s   = sel_s;
               next_tgt_we_s    = bus.req_we;
               next_tgt_addr_s  = bus.req_addr;
               next_tgt_wdata_s = bus.req_wdata;
               next_tgt_be_s    = bus.req_be;
               next_cnt_s       = '0;
            end else begin
               next_state_s = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (ack_sel_s) begin
               next_state_s     = ST_RESP;
               next_tgt_req_s   = 3'b000;
               next_rsp_valid_s = 1'b1;
               next_rsp_rdata_s = tgt_we_r ? 32'h0000_0000 : ack_rdata_s;
               next_rsp_err_s   = 1'b0;
            end else if (cnt_r == CNT_LAST) begin
               // target never answered: give up with an error
               next_state_s     = ST_RESP;
               next_tgt_req_s   = 3'b000;
               next_rsp_valid_s = 1'b1;
               next_rsp_rdata_s = 32'h0000_0000;
               next_rsp_err_s   = 1'b1;
            end else begin
               next_cnt_s = cnt_r + CNT_W'(1);
            end
         end
         ST_RESP: begin
            next_state_s = ST_IDLE;
         end
         default: begin
            next_state_s   = ST_IDLE;
            next_tgt_req_s = 3'b000;
         end
      endcase

      next_ready_s = (next_state_s == ST_IDLE);
   end

   // state and registered outputs; reset aborts any outstanding access
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         ready_r     <= 1'b1;
         tgt_req_r   <= 3'b000;
         tgt_we_r    <= 1'b0;
         tgt_addr_r  <= 32'h0000_0000;
         tgt_wdata_r <= 32'h0000_0000;
         tgt_be_r    <= 4'b0000;
         rsp_valid_r <= 1'b0;
         rsp_rdata_r <= 32'h0000_0000;
         rsp_err_r   <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         cnt_r       <= next_cnt_s;
         ready_r     <= next_ready_s;
         tgt_req_r   <= next_tgt_req_s;
         tgt_we_r    <= next_tgt_we_s;
         tgt_addr_r  <= next_tgt_addr_s;
         tgt_wdata_r <= next_tgt_wdata_s;
         tgt_be_r    <= next_tgt_be_s;
         rsp_valid_r <= next_rsp_valid_s;
         rsp_rdata_r <= next_rsp_rdata_s;
         rsp_err_r   <= next_rsp_err_s;
      end
   end

endmodule

// File: tb/tb_data_bus_demux.sv
// tb_data_bus_demux: table of directed accesses, randomized accesses checked
// against an address-map reference model, and reset corner sequences.
module tb_data_bus_demux;

   localparam int TIMEOUT = 16;
   localparam logic [31:0] BASE [3] = '{32'h0100_0000, 32'h8000_0000, 32'h0010_0000};
   localparam logic [31:0] MASK [3] = '{32'hFFFF_F000, 32'hFFFF_F000, 32'hFFFF_FF00};

   typedef struct {
      logic [2:0]  req;
      int          held;
      int          lat;
      logic        err;
      logic [31:0] rdata;
   } exp_t;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          delay;
      logic [2:0]  stray;
      logic [2:0]  req;
      int          held;
      int          lat;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   logic [31:0] rd_val [3];

   always #5 clk = ~clk;

   data_bus_demux_if bus ();

   data_bus_demux #(.TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
      end
   endtask

   task automatic set_rd(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      rd_val[0] = a; rd_val[1] = b; rd_val[2] = c;
      bus.tgt_rdata_0 = a; bus.tgt_rdata_1 = b; bus.tgt_rdata_2 = c;
   endtask

   // reference: address map lookup, then ack-delay vs timeout arithmetic
   function automatic exp_t model(input logic we, input logic [31:0] addr, input int delay);
      exp_t e;
      int   tgt = -1;
      for (int i = 0; i < 3; i++)
         if (tgt < 0 && (addr & MASK[i]) == BASE[i]) tgt = i;
      if (tgt < 0 || (addr % 4) != 0 || (tgt == 0 && we)) begin
         e = '{3'b000, 0, 1, 1'b1, 32'h0};
      end else if (delay < TIMEOUT) begin
         e = '{3'(1 << tgt), delay + 1, delay + 2, 1'b0, we ? 32'h0 : rd_val[tgt]};
      end else begin
         e = '{3'(1 << tgt), TIMEOUT, TIMEOUT + 1, 1'b1, 32'h0};
      end
      return e;
   endfunction

   // one access: targets ack after `delay` request cycles; `stray` acks non-selected targets
   task automatic run_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int delay,
                          input logic [2:0] stray, input exp_t e);
      int w = 0, cyc = 0, held = 0, lat = 0, bad_req = 0, bad_fld = 0;
      logic [31:0] got_rdata = 32'h0;
      logic        got_err = 1'b0;
      @(negedge clk);
      while (bus.req_ready !== 1'b1 && w < 20) begin
         @(negedge clk);
         w++;
      end
      chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid = 1'b1; bus.req_we = we; bus.req_addr = addr;
      bus.req_wdata = wdata; bus.req_be = be;
      while (cyc < 40 && lat == 0) begin
         @(negedge clk);
         cyc++;
         if (cyc == 1) begin
            bus.req_valid = 1'b0; bus.req_we = 1'($urandom_range(0, 1));
            bus.req_addr = $urandom; bus.req_wdata = $urandom; bus.req_be = 4'($urandom);
         end
         if (bus.rsp_valid === 1'b1) begin
            lat = cyc; got_rdata = bus.rsp_rdata; got_err = bus.rsp_err;
            bus.tgt_ack = 3'b000;
         end else begin
            if (bus.tgt_req !== 3'b000) begin
               held++;
               if (bus.tgt_req !== e.req) bad_req++;
               if ({bus.tgt_we, bus.tgt_addr, bus.tgt_wdata, bus.tgt_be} !== {we, addr, wdata, be})
                  bad_fld++;
            end
            bus.tgt_ack = stray & ~e.req;
            if (bus.tgt_req !== 3'b000 && held - 1 == delay) bus.tgt_ack = bus.tgt_ack | e.req;
         end
      end
      bus.tgt_ack = 3'b000;
      chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
      chk({tag, "_req_cycles"}, 32'(held), 32'(e.held));
      chk({tag, "_req_onehot"}, 32'(bad_req), 32'd0);
      chk({tag, "_tgt_fields"}, 32'(bad_fld), 32'd0);
      chk({tag, "_err"}, 32'(got_err), 32'(e.err));
      chk({tag, "_rdata"}, got_rdata, e.rdata);
      @(negedge clk);
      chk({tag, "_rsp_one_cycle"}, 32'(bus.rsp_valid), 32'd0);
      chk({tag, "_rdata_hold"}, bus.rsp_rdata, e.rdata);
      chk({tag, "_err_hold"}, 32'(bus.rsp_err), 32'(e.err));
      chk({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
   endtask

   initial begin
      vec_t vecs [10];
      exp_t e;
      int   quiet;

      // directed vectors with hand-derived expectations (rdata: t0=1111_0000, t1=DEAD_BEEF, t2=2222_0002)
      vecs[0] = '{1'b0, 32'h8000_0010, 32'h0, 4'hF, 0, 3'b000, 3'b010, 1, 2, 1'b0, 32'hDEAD_BEEF};
      vecs[1] = '{1'b1, 32'h0010_0004, 32'h0000_00A5, 4'b0001, 3, 3'b000, 3'b100, 4, 5, 1'b0, 32'h0};
      vecs[2] = '{1'b0, 32'h4000_0000, 32'h0, 4'hF, 0, 3'b000, 3'b000, 0, 1, 1'b1, 32'h0};
      vecs[3] = '{1'b0, 32'h8000_0002, 32'h0, 4'hF, 0, 3'b000, 3'b000, 0, 1, 1'b1, 32'h0};
      vecs[4] = '{1'b1, 32'h0100_0000, 32'h1234_5678, 4'hF, 0, 3'b000, 3'b000, 0, 1, 1'b1, 32'h0};
      vecs[5] = '{1'b0, 32'h0100_0000, 32'h0, 4'hF, 99, 3'b100, 3'b001, 16, 17, 1'b1, 32'h0};
      vecs[6] = '{1'b0, 32'h0100_0FFC, 32'h0, 4'hF, 1, 3'b110, 3'b001, 2, 3, 1'b0, 32'h1111_0000};
      vecs[7] = '{1'b0, 32'h0010_00FC, 32'h0, 4'hF, 15, 3'b011, 3'b100, 16, 17, 1'b0, 32'h2222_0002};
      vecs[8] = '{1'b1, 32'h8000_0FFC, 32'hCAFE_F00D, 4'hF, 0, 3'b101, 3'b010, 1, 2, 1'b0, 32'h0};
      vecs[9] = '{1'b0, 32'h0010_0100, 32'h0, 4'hF, 0, 3'b111, 3'b000, 0, 1, 1'b1, 32'h0};

      bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = 32'h0;
      bus.req_wdata = 32'h0; bus.req_be = 4'h0; bus.tgt_ack = 3'b000;
      set_rd(32'h1111_0000, 32'hDEAD_BEEF, 32'h2222_0002);

      // reset with a live request and acks pending: reset must win
      rst = 1'b1;
      bus.req_valid = 1'b1; bus.req_addr = 32'h8000_0000; bus.tgt_ack = 3'b111;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0; bus.req_valid = 1'b0; bus.tgt_ack = 3'b000;
      @(negedge clk);
      chk("rst_tgt_req", 32'(bus.tgt_req), 32'd0);
      chk("rst_tgt_we", 32'(bus.tgt_we), 32'd0);
      chk("rst_tgt_addr", bus.tgt_addr, 32'h0);
      chk("rst_tgt_wdata", bus.tgt_wdata, 32'h0);
      chk("rst_tgt_be", 32'(bus.tgt_be), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);

      // directed table
      for (int i = 0; i < 10; i++) begin
         e = '{vecs[i].req, vecs[i].held, vecs[i].lat, vecs[i].err, vecs[i].rdata};
         run_txn($sformatf("vec%0d", i), vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].be, vecs[i].delay, vecs[i].stray, e);
      end

      // reset in the second WAIT cycle of a data-memory load
      @(negedge clk);
      bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 32'h8000_0000;
      @(negedge clk);
      bus.req_valid = 1'b0;
      chk("midrst_req_set", 32'(bus.tgt_req), 32'd2);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_req_clear", 32'(bus.tgt_req), 32'd0);
      chk("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      rst = 1'b0;
      quiet = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.rsp_valid !== 1'b0 || bus.tgt_req !== 3'b000) quiet++;
      end
      chk("midrst_quiet", 32'(quiet), 32'd0);
      e = model(1'b0, 32'h8000_0020, 0);
      run_txn("midrst_next", 1'b0, 32'h8000_0020, 32'h0, 4'hF, 0, 3'b000, e);

      // randomized accesses against the reference model
      for (int n = 0; n < 40; n++) begin
         logic        we;
         logic [31:0] addr;
         int          delay;
         set_rd($urandom, $urandom, $urandom);
         case ($urandom_range(0, 4))
            0:       addr = BASE[0] | ($urandom & 32'h0000_0FFF);
            1:       addr = BASE[1] | ($urandom & 32'h0000_0FFF);
            2:       addr = BASE[2] | ($urandom & 32'h0000_00FF);
            3:       addr = $urandom;
            default: addr = BASE[$urandom_range(0, 2)] + 32'h0000_1000;
         endcase
         if ($urandom_range(0, 5) != 0) addr[1:0] = 2'b00;
         we    = 1'($urandom_range(0, 1));
         delay = $urandom_range(0, 19);
         e     = model(we, addr, delay);
         run_txn($sformatf("rnd%0d", n), we, addr, $urandom, 4'($urandom), delay,
                 3'($urandom), e);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
